multi_user_free_queue: RTL and testbench
========================================

Name: multi_user_free_queue

Overview:
- Free-pointer queue for the shared cell buffer of the 4-port switch core.
- Hands out free cell pointers to the ingress writer and takes back pointers that egress has released once their multicast count reaches zero.
- After reset it self-initialises with every cell pointer 0..PTR_NUM-1.
- It is a first-word-fall-through FIFO of 10-bit pointers.

Parameters:
- PTR_NUM, 512, number of cell pointers managed (cell buffer of 2048 x 128-bit words, 4 words per cell).
- PTR_W, 10, pointer width on the output port.
- CNT_W, 10, width of the internal occupancy counter; must hold PTR_NUM.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ptr_din  in  16  returned pointer; only [PTR_W-1:0] is stored, [15:PTR_W] is ignored.
- FQ_wr  in  1  push ptr_din into the queue at this edge.
- FQ_rd  in  1  pop the head pointer at this edge.
- ptr_dout_s  out  10  head pointer, valid whenever ptr_fifo_empty=0 (show-ahead).
- ptr_fifo_empty  out  1  1 = no free pointer available.

Behaviour:
- Storage: PTR_NUM x PTR_W array, rd_ptr/wr_ptr (log2 PTR_NUM bits, natural wrap at PTR_NUM), occupancy counter cnt (0..PTR_NUM).
- Reset (rst=1, async): rd_ptr=0, wr_ptr=0, cnt=0, init_cnt=0, state=INIT; ptr_fifo_empty=1; ptr_dout_s=0.
- Reset asserted mid-operation (including mid-INIT) discards all contents and restarts INIT.
- State INIT:
  - Each clock writes mem[init_cnt]=init_cnt, then init_cnt++, wr_ptr++, cnt++.
  - After PTR_NUM cycles, cnt=PTR_NUM and wr_ptr has wrapped to 0; go to RUN.
  - External FQ_wr and FQ_rd are ignored in INIT.
  - ptr_fifo_empty stays 1 throughout INIT.
- State RUN:
  - ptr_fifo_empty = (cnt==0), derived from registered state with no combinational path from the inputs.
  - ptr_dout_s = mem[rd_ptr] when not empty, else 0; combinational from registered rd_ptr/array.
  - FQ_rd with cnt>0: rd_ptr++, cnt--; the new head is visible on ptr_dout_s the following cycle.
  - FQ_rd with cnt==0: ignored; no pointer or count change.
  - FQ_wr with cnt<PTR_NUM: mem[wr_ptr]=ptr_din[PTR_W-1:0], wr_ptr++, cnt++.
  - FQ_wr with cnt==PTR_NUM: ignored (overflow dropped; cannot occur in correct system use).
  - FQ_wr and FQ_rd in the same cycle with cnt>0: both performed, cnt unchanged.
  - FQ_wr and FQ_rd in the same cycle with cnt==0: write performed, read ignored, cnt becomes 1.
- Latency:
  - Push to visible-at-head is 1 clock when the queue was empty.
  - Pop to next head is 1 clock.
- No duplicate detection; the queue stores whatever is returned, in FIFO order.
- Users: one reader (ingress writer, FQ_rd at most once per 4 cycles) and one writer (egress, FQ_wr). Both must be correct for back-to-back FQ_rd/FQ_wr every cycle regardless.

Test Plan:
- Reset, then release and clock 512 cycles -> ptr_fifo_empty=1 for cycles 0..511; at cycle 512 empty=0 and ptr_dout_s=0.
- After init, pulse FQ_rd 3 times on consecutive cycles -> ptr_dout_s sequence 0,1,2, then 3 remains at head.
- Drain: 512 consecutive FQ_rd -> heads 0..511 in order, then empty=1 and ptr_dout_s=0. An extra FQ_rd while empty changes nothing.
- From empty, FQ_wr with ptr_din=16'hFC2A -> next cycle empty=0, ptr_dout_s=10'h02A. Then FQ_wr and FQ_rd together with ptr_din=5 -> head becomes 5 and occupancy stays 1.
- Full queue after init, FQ_wr with ptr_din=7 -> dropped. Drain 512 -> values 0..511 only, 7 never appears.
- Assert rst during INIT at cycle 200, release -> empty=1 for a further 512 cycles, then head=0.

Source files
------------

// File: rtl/multi_user_free_queue_if.sv
// ---------------------------------------------------------------------------
// multi_user_free_queue_if
// Handshake bundle between the free-pointer queue and its two users.
//   ptr_din        16  returned pointer from egress (low PTR_W bits stored)
//   FQ_wr           1  push ptr_din this clock
//   FQ_rd           1  pop the head pointer this clock
//   ptr_dout_s  PTR_W  head pointer, show-ahead, valid when not empty
//   ptr_fifo_empty  1  no free pointer available
// master = user side (drives requests), slave = queue side.
// ---------------------------------------------------------------------------
interface multi_user_free_queue_if #(
   parameter int PTR_W = 10
);
   logic [15:0]      ptr_din;
   logic             FQ_wr;
   logic             FQ_rd;
   logic [PTR_W-1:0] ptr_dout_s;
   logic             ptr_fifo_empty;

   modport master (
      output ptr_din, FQ_wr, FQ_rd,
      input  ptr_dout_s, ptr_fifo_empty
   );

   modport slave (
      input  ptr_din, FQ_wr, FQ_rd,
      output ptr_dout_s, ptr_fifo_empty
   );
endinterface

// File: rtl/multi_user_free_queue.sv
// ---------------------------------------------------------------------------
// multi_user_free_queue
// First-word-fall-through queue of free cell pointers for the shared cell
// buffer. After reset it fills itself with pointers 0..PTR_NUM-1 (one per
// clock), then hands pointers to the ingress writer (FQ_rd) and takes back
// pointers released by egress (FQ_wr).
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset; discards contents, restarts fill
//   fq   slave side of multi_user_free_queue_if (ptr_din, FQ_wr, FQ_rd,
//        ptr_dout_s, ptr_fifo_empty)
// ---------------------------------------------------------------------------
module multi_user_free_queue #(
   parameter int PTR_NUM = 512,
   parameter int PTR_W   = 10,
   parameter int CNT_W   = 10
) (
   input  logic                    clk,
   input  logic                    rst,
   multi_user_free_queue_if.slave  fq
);

   localparam int AW = $clog2(PTR_NUM);

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t              state;
   logic [AW-1:0]       rd_ptr;
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       init_cnt;
   logic [CNT_W-1:0]    cnt;
   logic [PTR_W-1:0]    mem [PTR_NUM];

   logic                q_empty;
   logic                q_full;
   logic                do_wr;
   logic                do_rd;
   logic [PTR_W-1:0]    wr_data;
   logic                unused_din_hi;

   // Upper bits of the returned pointer carry no information here.
   assign unused_din_hi = ^fq.ptr_din[15:PTR_W];

   // Qualify requests against the registered occupancy. During the fill
   // the array port belongs to the initialiser and user requests are
   // ignored.
   always_comb begin
      q_empty = (cnt == '0);
      q_full  = (cnt == CNT_W'(PTR_NUM));
      do_wr   = 1'b0;
      do_rd   = 1'b0;
      wr_data = fq.ptr_din[PTR_W-1:0];
      if (state == S_INIT) begin
         do_wr   = 1'b1;
         wr_data = PTR_W'(init_cnt);
      end else begin
         do_wr = fq.FQ_wr && !q_full;
         do_rd = fq.FQ_rd && !q_empty;
      end
   end

   // Pointer storage: data only, no reset.
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Control: fill sequencer and read/write pointers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_INIT;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         cnt      <= '0;
         init_cnt <= '0;
      end else begin
         case (state)
            S_INIT: begin
               wr_ptr   <= wr_ptr + 1'b1;
               cnt      <= cnt + 1'b1;
               init_cnt <= init_cnt + 1'b1;
               // wr_ptr wraps to 0 on this same edge
               if (init_cnt == AW'(PTR_NUM - 1)) begin
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               if (do_wr) wr_ptr <= wr_ptr + 1'b1;
               if (do_rd) rd_ptr <= rd_ptr + 1'b1;
               // Simultaneous push and pop leaves occupancy unchanged.
               case ({do_wr, do_rd})
                  2'b10:   cnt <= cnt + 1'b1;
                  2'b01:   cnt <= cnt - 1'b1;
                  default: cnt <= cnt;
               endcase
            end
            default: state <= S_INIT;
         endcase
      end
   end

   // Show-ahead outputs, purely from registered state.
   assign fq.ptr_fifo_empty = (state != S_RUN) || q_empty;
   assign fq.ptr_dout_s     = fq.ptr_fifo_empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_multi_user_free_queue.sv
// ---------------------------------------------------------------------------
// tb_multi_user_free_queue
// Self-checking bench for multi_user_free_queue: vector table, hand-written
// sequences for fill/drain/overflow/reset-during-fill, and randomized
// traffic against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_multi_user_free_queue;

   localparam int PTR_NUM = 512;

   logic clk;
   logic rst;

   multi_user_free_queue_if #(.PTR_W(10)) fq_if ();

   multi_user_free_queue #(
      .PTR_NUM (PTR_NUM),
      .PTR_W   (10),
      .CNT_W   (10)
   ) dut (
      .clk (clk),
      .rst (rst),
      .fq  (fq_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: a plain queue of pointer values plus a fill countdown.
   int mq[$];
   int m_init_left;
   int m_init_val;

   typedef struct {
      bit          wr;
      bit          rd;
      logic [15:0] din;
      bit          exp_empty;
      logic [9:0]  exp_dout;
   } vec_t;

   vec_t tbl[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_init_left = PTR_NUM;
      m_init_val  = 0;
   endtask

   task automatic model_step(input bit wr, input bit rd, input logic [15:0] din);
      int sz;
      if (m_init_left > 0) begin
         mq.push_back(m_init_val);
         m_init_val++;
         m_init_left--;
      end else begin
         sz = mq.size();
         if (rd && sz > 0) void'(mq.pop_front());
         if (wr && sz < PTR_NUM) mq.push_back(int'(din[9:0]));
      end
   endtask

   function automatic bit model_empty();
      return (m_init_left > 0) || (mq.size() == 0);
   endfunction

   function automatic int model_head();
      return model_empty() ? 0 : mq[0];
   endfunction

   // One clock: drive requests, take the edge, advance the model.
   task automatic cycle(input bit wr, input bit rd, input logic [15:0] din);
      fq_if.FQ_wr   = wr;
      fq_if.FQ_rd   = rd;
      fq_if.ptr_din = din;
      @(posedge clk);
      #1;
      model_step(wr, rd, din);
      fq_if.FQ_wr = 1'b0;
      fq_if.FQ_rd = 1'b0;
   endtask

   // Asynchronous reset asserted between edges, held over one edge.
   task automatic do_reset();
      rst = 1'b1;
      fq_if.FQ_wr = 1'b0;
      fq_if.FQ_rd = 1'b0;
      #2;
      check("reset_empty", 32'(fq_if.ptr_fifo_empty), 32'd1);
      check("reset_dout", 32'(fq_if.ptr_dout_s), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic wait_init();
      for (int c = 0; c < PTR_NUM; c++) cycle(1'b0, 1'b0, 16'h0);
   endtask

   task automatic random_phase(input int n, input int pw, input int pr);
      bit          w;
      bit          r;
      logic [15:0] d;
      for (int i = 0; i < n; i++) begin
         w = ($urandom_range(99) < pw);
         r = ($urandom_range(99) < pr);
         d = 16'($urandom);
         cycle(w, r, d);
         check("rand_empty", 32'(fq_if.ptr_fifo_empty), 32'(model_empty()));
         check("rand_dout", 32'(fq_if.ptr_dout_s), 32'(model_head()));
      end
   endtask

   initial begin
      rst           = 1'b1;
      fq_if.FQ_wr   = 1'b0;
      fq_if.FQ_rd   = 1'b0;
      fq_if.ptr_din = 16'h0;

      // {wr, rd, din, expected empty, expected head after the edge}
      tbl[0] = '{1'b0, 1'b1, 16'h0000, 1'b0, 10'd1};
      tbl[1] = '{1'b0, 1'b1, 16'h0000, 1'b0, 10'd2};
      tbl[2] = '{1'b0, 1'b1, 16'h0000, 1'b0, 10'd3};
      tbl[3] = '{1'b0, 1'b0, 16'h0000, 1'b0, 10'd3};
      tbl[4] = '{1'b1, 1'b0, 16'hFC2A, 1'b0, 10'd3};
      tbl[5] = '{1'b1, 1'b1, 16'h0005, 1'b0, 10'd4};

      // Fill after reset: empty for cycles 0..511, head 0 at 512.
      // Random requests during the fill must be ignored.
      do_reset();
      check("init_empty_c0", 32'(fq_if.ptr_fifo_empty), 32'd1);
      for (int c = 1; c <= PTR_NUM; c++) begin
         cycle(1'($urandom), 1'($urandom), 16'($urandom));
         if (c < PTR_NUM) begin
            check("init_empty", 32'(fq_if.ptr_fifo_empty), 32'd1);
         end else begin
            check("init_done_empty", 32'(fq_if.ptr_fifo_empty), 32'd0);
            check("init_done_head", 32'(fq_if.ptr_dout_s), 32'd0);
         end
      end

      // Vector table from the freshly filled queue.
      for (int i = 0; i < 6; i++) begin
         cycle(tbl[i].wr, tbl[i].rd, tbl[i].din);
         check("tbl_empty", 32'(fq_if.ptr_fifo_empty), 32'(tbl[i].exp_empty));
         check("tbl_dout", 32'(fq_if.ptr_dout_s), 32'(tbl[i].exp_dout));
      end

      // Randomized traffic: mixed, draining, filling to full, saturated.
      random_phase(800, 50, 50);
      random_phase(800, 15, 85);
      random_phase(1500, 85, 10);
      random_phase(800, 95, 95);

      // Overflow drop, full drain, empty behaviour, refill corner cases.
      do_reset();
      wait_init();
      cycle(1'b1, 1'b0, 16'd7);
      check("ovf_head", 32'(fq_if.ptr_dout_s), 32'd0);
      for (int i = 0; i < PTR_NUM; i++) begin
         check("drain_head", 32'(fq_if.ptr_dout_s), 32'(i));
         cycle(1'b0, 1'b1, 16'h0);
      end
      check("drain_empty", 32'(fq_if.ptr_fifo_empty), 32'd1);
      check("drain_dout", 32'(fq_if.ptr_dout_s), 32'd0);
      cycle(1'b0, 1'b1, 16'h0);
      check("rd_empty_empty", 32'(fq_if.ptr_fifo_empty), 32'd1);
      check("rd_empty_dout", 32'(fq_if.ptr_dout_s), 32'd0);
      cycle(1'b1, 1'b0, 16'hFC2A);
      check("push_empty", 32'(fq_if.ptr_fifo_empty), 32'd0);
      check("push_dout", 32'(fq_if.ptr_dout_s), 32'h02A);
      cycle(1'b1, 1'b1, 16'd5);
      check("wrrd_empty", 32'(fq_if.ptr_fifo_empty), 32'd0);
      check("wrrd_dout", 32'(fq_if.ptr_dout_s), 32'd5);
      cycle(1'b0, 1'b1, 16'h0);
      check("occ_one_empty", 32'(fq_if.ptr_fifo_empty), 32'd1);
      // Push and pop together on an empty queue: write only.
      cycle(1'b1, 1'b1, 16'd9);
      check("wrrd_on_empty", 32'(fq_if.ptr_dout_s), 32'd9);
      cycle(1'b0, 1'b1, 16'h0);
      check("wrrd_on_empty_occ", 32'(fq_if.ptr_fifo_empty), 32'd1);

      // Reset in the middle of the fill restarts it completely.
      do_reset();
      for (int c = 0; c < 200; c++) cycle(1'b0, 1'b0, 16'h0);
      check("midinit_empty", 32'(fq_if.ptr_fifo_empty), 32'd1);
      do_reset();
      for (int c = 1; c <= PTR_NUM; c++) begin
         cycle(1'b0, 1'b0, 16'h0);
         if (c < PTR_NUM) check("reinit_empty", 32'(fq_if.ptr_fifo_empty), 32'd1);
      end
      check("reinit_done_empty", 32'(fq_if.ptr_fifo_empty), 32'd0);
      check("reinit_head", 32'(fq_if.ptr_dout_s), 32'd0);
      cycle(1'b0, 1'b1, 16'h0);
      check("reinit_next", 32'(fq_if.ptr_dout_s), 32'd1);
      check("reinit_model", 32'(fq_if.ptr_dout_s), 32'(model_head()));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
